lock_supervisor: RTL

//  Downstream supervisor for digital_lock. Watches the lock's y and state outputs, turns an unlock

---
 rtl/lock_supervisor.sv | 95 +++++++++
 1 files changed

// File: rtl/lock_supervisor.sv
// rtl/lock_supervisor.sv - door-open window and failed-attempt lockout supervisor for digital_lock
module lock_supervisor #(
  parameter int OPEN_CYCLES    = 8,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int CNT_W          = 8,
  parameter int FAIL_W         = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              y,
  input  logic [1:0]        state,
  output logic              door_open,
  output logic              alarm,
  output logic              input_block,
  output logic [FAIL_W-1:0] fail_count,
  output logic [1:0]        sup_state
);

  typedef enum logic [1:0] {
    ARMED   = 2'b00,
    OPEN    = 2'b01,
    LOCKOUT = 2'b10,
    UNUSED  = 2'b11
  } sup_t;

  localparam logic [CNT_W-1:0]  OPEN_LOAD    = CNT_W'(OPEN_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LOCKOUT_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [FAIL_W-1:0] FAIL_LAST    = FAIL_W'(MAX_FAILS - 1);
  localparam logic [FAIL_W-1:0] FAIL_SAT     = FAIL_W'(MAX_FAILS);

  sup_t             cur;
  logic [CNT_W-1:0] timer;
  logic             prev_y;
  logic [1:0]       prev_state;
  logic             unlock_evt;
  logic             fail_evt;

  // An attempt is aborted when the lock falls back to S0 from S1 or S2; S3->S0 is a normal exit.
  assign unlock_evt = y & ~prev_y;
  assign fail_evt   = ((prev_state == 2'b01) || (prev_state == 2'b10)) && (state == 2'b00);

  assign sup_state   = cur;
  assign door_open   = (cur == OPEN);
  assign alarm       = (cur == LOCKOUT);
  assign input_block = (cur == LOCKOUT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur        <= ARMED;
      timer      <= '0;
      fail_count <= '0;
      prev_y     <= 1'b0;
      prev_state <= 2'b00;
    end else begin
      prev_y     <= y;
      prev_state <= state;
      case (cur)
        ARMED: begin
          if (unlock_evt) begin
            cur        <= OPEN;
            timer      <= OPEN_LOAD;
            fail_count <= '0;
          end else if (fail_evt) begin
            if (fail_count == FAIL_LAST) begin
              cur        <= LOCKOUT;
              timer      <= LOCKOUT_LOAD;
              fail_count <= FAIL_SAT;
            end else begin
              fail_count <= fail_count + 1'b1;
            end
          end
        end
        OPEN: begin
          if (timer == '0) cur <= ARMED;
          else             timer <= timer - 1'b1;
        end
        LOCKOUT: begin
          if (timer == '0) begin
            cur        <= ARMED;
            fail_count <= '0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          cur        <= ARMED;
          timer      <= '0;
          fail_count <= '0;
        end
      endcase
    end
  end

endmodule
